mvm_activation: RTL and testbench

//  Post-MVM output stage. Captures the packed result_vector of an mvm instance, adds a per-row

---
 rtl/mvm_activation.sv | 166 ++++++++++++++++
 tb/tb_mvm_activation.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mvm_activation.sv
// Post-MVM output stage: bias add, ReLU and one-element-per-beat valid/ready streaming.
// Optional build macro MVM_ACT_SAT_EN selects saturating activation instead of wrap-then-ReLU.
module mvm_activation #(
    parameter  int MATRIX_ROWS = 3,
    parameter  int WIDTH       = 8,
    localparam int IDX_W       = (MATRIX_ROWS > 1) ? $clog2(MATRIX_ROWS) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [MATRIX_ROWS*WIDTH-1:0] result_vector,
    input  logic [MATRIX_ROWS*WIDTH-1:0] bias_vector,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [IDX_W-1:0]             out_index,
    output logic                         out_last
);

    localparam int               ELEMS    = 2 ** IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MATRIX_ROWS - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                       r_state;
    logic                         r_in_ready;
    logic                         r_out_valid;
    logic [WIDTH-1:0]             r_out_data;
    logic [IDX_W-1:0]             r_out_index;
    logic                         r_out_last;
    logic [MATRIX_ROWS*WIDTH-1:0] r_result;
    logic [MATRIX_ROWS*WIDTH-1:0] r_bias;

    state_t                       w_state_nxt;
    logic                         w_in_ready_nxt;
    logic                         w_valid_nxt;
    logic [WIDTH-1:0]             w_data_nxt;
    logic [IDX_W-1:0]             w_index_nxt;
    logic                         w_last_nxt;
    logic                         w_capture;
    logic [IDX_W-1:0]             w_next_idx;
    logic [WIDTH-1:0]             w_res_elem  [ELEMS];
    logic [WIDTH-1:0]             w_bias_elem [ELEMS];

    // Bias add plus activation for one element.
    function automatic logic [WIDTH-1:0] f_activate(input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b);
`ifdef MVM_ACT_SAT_EN
        logic [WIDTH:0] sum;
        sum = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        if (sum[WIDTH]) begin
            return {WIDTH{1'b0}};
        end else if (sum[WIDTH-1]) begin
            return {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            return sum[WIDTH-1:0];
        end
`else
        // Only the low WIDTH bits of the widened sum survive the wrap, so add narrow.
        logic [WIDTH-1:0] r;
        r = a + b;
        if (r[WIDTH-1]) begin
            return {WIDTH{1'b0}};
        end else begin
            return r;
        end
`endif
    endfunction

    // Unpack latched vectors into element arrays; padding entries beyond the last row read 0.
    for (genvar g = 0; g < ELEMS; g++) begin : g_elem
        if (g < MATRIX_ROWS) begin : g_live
            assign w_res_elem[g]  = r_result[(MATRIX_ROWS-g)*WIDTH-1 -: WIDTH];
            assign w_bias_elem[g] = r_bias[(MATRIX_ROWS-g)*WIDTH-1 -: WIDTH];
        end else begin : g_pad
            assign w_res_elem[g]  = {WIDTH{1'b0}};
            assign w_bias_elem[g] = {WIDTH{1'b0}};
        end
    end

    assign w_next_idx = r_out_index + IDX_W'(1'b1);

    // Next-state and next-output decode for the IDLE/RUN sequencer.
    always_comb begin
        w_state_nxt = r_state;
        w_valid_nxt = r_out_valid;
        w_data_nxt  = r_out_data;
        w_index_nxt = r_out_index;
        w_last_nxt  = r_out_last;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    // Element 0 comes straight from the ports since the latch is not loaded yet.
                    w_capture   = 1'b1;
                    w_state_nxt = ST_RUN;
                    w_valid_nxt = 1'b1;
                    w_data_nxt  = f_activate(result_vector[MATRIX_ROWS*WIDTH-1 -: WIDTH],
                                             bias_vector[MATRIX_ROWS*WIDTH-1 -: WIDTH]);
                    w_index_nxt = {IDX_W{1'b0}};
                    w_last_nxt  = (LAST_IDX == {IDX_W{1'b0}});
                end else begin
                    w_valid_nxt = 1'b0;
                end
            end
            ST_RUN: begin
                if (r_out_valid && out_ready) begin
                    if (r_out_last) begin
                        w_state_nxt = ST_IDLE;
                        w_valid_nxt = 1'b0;
                    end else begin
                        w_data_nxt  = f_activate(w_res_elem[w_next_idx], w_bias_elem[w_next_idx]);
                        w_index_nxt = w_next_idx;
                        w_last_nxt  = (w_next_idx == LAST_IDX);
                    end
                end else begin
                    w_valid_nxt = r_out_valid;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase
        w_in_ready_nxt = (w_state_nxt == ST_IDLE);
    end

    // State, output and capture registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= {WIDTH{1'b0}};
            r_out_index <= {IDX_W{1'b0}};
            r_out_last  <= 1'b0;
            r_result    <= {(MATRIX_ROWS*WIDTH){1'b0}};
            r_bias      <= {(MATRIX_ROWS*WIDTH){1'b0}};
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_valid_nxt;
            r_out_data  <= w_data_nxt;
            r_out_index <= w_index_nxt;
            r_out_last  <= w_last_nxt;
            if (w_capture) begin
                r_result <= result_vector;
                r_bias   <= bias_vector;
            end else begin
                r_result <= r_result;
                r_bias   <= r_bias;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_index = r_out_index;
    assign out_last  = r_out_last;

endmodule

// File: tb/tb_mvm_activation.sv
// Self-checking bench for mvm_activation: table vectors, handshake corner cases and
// randomized vectors/backpressure checked against an arithmetic reference model.
module tb_mvm_activation;

    localparam int ROWS = 3;
    localparam int W    = 8;

    logic            clk;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [ROWS*W-1:0] result_vector;
    logic [ROWS*W-1:0] bias_vector;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    out_data;
    logic [1:0]      out_index;
    logic            out_last;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] got_data [$];
    logic [1:0] got_idx  [$];
    logic       got_last [$];
    int         got_cycles;

    typedef struct {
        logic [23:0] res;
        logic [23:0] bias;
        logic [23:0] exp;
    } vec_t;

    mvm_activation #(.MATRIX_ROWS(ROWS), .WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .result_vector(result_vector), .bias_vector(bias_vector),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_index(out_index), .out_last(out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference activation from plain integer arithmetic.
    function automatic logic [7:0] model_act(input logic [7:0] r, input logic [7:0] b);
        int sr, sb, s, w;
        sr = $signed(r);
        sb = $signed(b);
        s  = sr + sb;
`ifdef MVM_ACT_SAT_EN
        if (s < 0) w = 0;
        else if (s > 127) w = 127;
        else w = s;
`else
        w = ((s % 256) + 256) % 256;
        if (w >= 128) w = 0;
`endif
        return w[7:0];
    endfunction

    function automatic logic [23:0] model_vec(input logic [23:0] res, input logic [23:0] bias);
        logic [23:0] e;
        for (int i = 0; i < ROWS; i++)
            e[(ROWS-i)*8-1 -: 8] = model_act(res[(ROWS-i)*8-1 -: 8], bias[(ROWS-i)*8-1 -: 8]);
        return e;
    endfunction

    // Send one vector, drain its beats under the requested out_ready pattern, check the stream.
    task automatic send_vec(input logic [23:0] res, input logic [23:0] bias, input logic [23:0] exp,
                            input int stall_idx, input int stall_len, input bit rnd_ready,
                            input bit inject);
        int cyc, stalls;
        bit done, prev_stall, rdy;
        logic [7:0] h_data;
        logic [1:0] h_idx;
        logic       h_last;
        logic [23:0] e;
        e = exp;
        @(negedge clk);
        chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
        result_vector = res;
        bias_vector   = bias;
        in_valid      = 1'b1;
        out_ready     = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        got_data.delete(); got_idx.delete(); got_last.delete();
        cyc = 0; stalls = 0; done = 1'b0; prev_stall = 1'b0;
        h_data = 8'h00; h_idx = 2'd0; h_last = 1'b0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            chk("valid_in_run", {31'd0, out_valid}, 32'd1);
            chk("in_ready_run", {31'd0, in_ready}, 32'd0);
            if (prev_stall) begin
                chk("hold_data", {24'd0, out_data}, {24'd0, h_data});
                chk("hold_idx", {30'd0, out_index}, {30'd0, h_idx});
                chk("hold_last", {31'd0, out_last}, {31'd0, h_last});
            end
            if (inject && cyc == 1) begin
                in_valid      = 1'b1;
                result_vector = 24'h010101;
                bias_vector   = 24'h010101;
            end else begin
                in_valid = 1'b0;
            end
            if (stall_idx >= 0 && int'(out_index) == stall_idx && stalls < stall_len) begin
                rdy = 1'b0;
                stalls++;
            end else if (rnd_ready) begin
                rdy = ($urandom_range(0, 2) != 0);
            end else begin
                rdy = 1'b1;
            end
            out_ready = rdy;
            if (out_valid && rdy) begin
                got_data.push_back(out_data);
                got_idx.push_back(out_index);
                got_last.push_back(out_last);
                if (out_last) done = 1'b1;
            end
            prev_stall = out_valid && !rdy;
            h_data = out_data; h_idx = out_index; h_last = out_last;
            cyc++;
        end
        in_valid   = 1'b0;
        got_cycles = cyc;
        if (!done) chk("stream_timeout", 32'd0, 32'd1);
        @(negedge clk);
        chk("valid_after_last", {31'd0, out_valid}, 32'd0);
        chk("in_ready_after_last", {31'd0, in_ready}, 32'd1);
        chk("beat_count", got_data.size(), ROWS);
        for (int i = 0; i < ROWS && i < got_data.size(); i++) begin
            chk("beat_data", {24'd0, got_data[i]}, {24'd0, e[(ROWS-i)*8-1 -: 8]});
            chk("beat_idx", {30'd0, got_idx[i]}, i);
            chk("beat_last", {31'd0, got_last[i]}, (i == ROWS-1) ? 32'd1 : 32'd0);
        end
    endtask

    vec_t tbl [5];

    initial begin
        tbl[0] = '{res: 24'h0E2032, bias: 24'h010203, exp: 24'h0F2235};
        tbl[1] = '{res: 24'h0E2032, bias: 24'hF0F0F0, exp: 24'h001022};
`ifdef MVM_ACT_SAT_EN
        tbl[2] = '{res: 24'h7F6040, bias: 24'h013040, exp: 24'h7F7F7F};
        tbl[3] = '{res: 24'h7F0180, bias: 24'h7FFF7F, exp: 24'h7F0000};
`else
        tbl[2] = '{res: 24'h7F6040, bias: 24'h013040, exp: 24'h000000};
        tbl[3] = '{res: 24'h7F0180, bias: 24'h7FFF7F, exp: 24'h000000};
`endif
        tbl[4] = '{res: 24'h807F00, bias: 24'h8000FF, exp: 24'h007F00};

        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        result_vector = 24'h0; bias_vector = 24'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        chk("rst_out_index", {30'd0, out_index}, 32'd0);
        chk("rst_out_last", {31'd0, out_last}, 32'd0);
        reset = 1'b1;

        for (int t = 0; t < 5; t++) begin
            send_vec(tbl[t].res, tbl[t].bias, tbl[t].exp, -1, 0, 1'b0, 1'b0);
            chk("full_rate_cycles", got_cycles, ROWS);
        end

        // Backpressure on row 1 for three cycles.
        send_vec(24'h0E2032, 24'h010203, 24'h0F2235, 1, 3, 1'b0, 1'b0);
        chk("stall_cycles", got_cycles, ROWS + 3);

        // in_valid pulsed mid-stream must not disturb the stream.
        send_vec(24'h0E2032, 24'h010203, 24'h0F2235, -1, 0, 1'b0, 1'b1);

        // Reset after beat 0 abandons the stream.
        @(negedge clk);
        result_vector = 24'h0E2032; bias_vector = 24'h010203; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_beat0", {24'd0, out_data}, 32'h0F);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_out_index", {30'd0, out_index}, 32'd0);
        chk("midrst_out_last", {31'd0, out_last}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("postrst_no_beat", {31'd0, out_valid}, 32'd0);
        send_vec(24'h0E2032, 24'hF0F0F0, 24'h001022, -1, 0, 1'b0, 1'b0);

        // Random vectors with random backpressure against the reference model.
        for (int n = 0; n < 30; n++) begin
            logic [23:0] r, b;
            r = 24'($urandom);
            b = 24'($urandom);
            send_vec(r, b, model_vec(r, b), -1, 0, 1'b1, (n % 4) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
